// File: rtl/text_console_writer_if.sv
// +-----------------------------------------------------------------------+
// | text_console_writer_if                                                |
// | Byte stream in, character/colour buffer write port and cursor out.    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

interface text_console_writer_if;
  logic       sL;
  logic       char_valid;
  logic [6:0] char_ascii;
  logic [5:0] char_colour;
  logic       char_ready;
  logic       wr_en;
  logic [6:0] wr_x;
  logic [5:0] wr_y;
  logic [6:0] wr_ascii;
  logic [5:0] wr_colour;
  logic [6:0] cur_x;
  logic [5:0] cur_y;

  // Byte source / buffer observer side
  modport master (
    output sL, char_valid, char_ascii, char_colour,
    input  char_ready, wr_en, wr_x, wr_y, wr_ascii, wr_colour, cur_x, cur_y
  );

  // Console writer side
  modport slave (
    input  sL, char_valid, char_ascii, char_colour,
    output char_ready, wr_en, wr_x, wr_y, wr_ascii, wr_colour, cur_x, cur_y
  );
endinterface

`default_nettype wire

// File: rtl/text_console_writer.sv
// +-----------------------------------------------------------------------+
// | text_console_writer                                                   |
// | Turns an ASCII byte stream into cursor-driven text buffer writes.     |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module text_console_writer (
  input  logic                 clk,
  input  logic                 reset,
  text_console_writer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PEND    = 2'd1,
    S_CLR_ROW = 2'd2,
    S_CLR_SCR = 2'd3
  } state_t;

  localparam logic [6:0] c_COLS_SMALL = 7'd80;
  localparam logic [6:0] c_COLS_LARGE = 7'd40;
  localparam logic [5:0] c_TOP_SMALL  = 6'd59;
  localparam logic [5:0] c_TOP_LARGE  = 6'd29;
  localparam logic [6:0] c_SPACE      = 7'h20;
  localparam logic [5:0] c_BLACK      = 6'd0;

  state_t     r_state, w_state_nxt;
  logic       r_mode, w_mode_nxt;
  logic [6:0] r_cur_x, w_cur_x_nxt;
  logic [5:0] r_cur_y, w_cur_y_nxt;
  logic [6:0] r_clr_x, w_clr_x_nxt;
  logic [5:0] r_clr_y, w_clr_y_nxt;
  logic       r_wr_en, w_wr_en_nxt;
  logic [6:0] r_wr_x, w_wr_x_nxt;
  logic [5:0] r_wr_y, w_wr_y_nxt;
  logic [6:0] r_wr_ascii, w_wr_ascii_nxt;
  logic [5:0] r_wr_colour, w_wr_colour_nxt;

  logic [6:0] w_cols;
  logic [6:0] w_last_x;
  logic [5:0] w_top;
  logic [5:0] w_top_sl;
  logic [5:0] w_next_row;
  logic       w_mismatch;
  logic       w_accept;
  logic       w_printable;

  assign w_cols      = r_mode ? c_COLS_LARGE : c_COLS_SMALL;
  assign w_last_x    = w_cols - 7'd1;
  assign w_top       = r_mode ? c_TOP_LARGE : c_TOP_SMALL;
  assign w_top_sl    = bus.sL ? c_TOP_LARGE : c_TOP_SMALL;
  // Rows count down the screen, wrapping from the bottom back to the top
  assign w_next_row  = (r_cur_y == 6'd0) ? w_top : r_cur_y - 6'd1;
  assign w_mismatch  = (bus.sL != r_mode);
  assign w_printable = (bus.char_ascii >= 7'h20) && (bus.char_ascii != 7'h7F);

  assign bus.char_ready = (r_state == S_IDLE) && !w_mismatch;
  assign w_accept       = bus.char_valid && bus.char_ready;

  assign bus.wr_en     = r_wr_en;
  assign bus.wr_x      = r_wr_x;
  assign bus.wr_y      = r_wr_y;
  assign bus.wr_ascii  = r_wr_ascii;
  assign bus.wr_colour = r_wr_colour;
  assign bus.cur_x     = r_cur_x;
  assign bus.cur_y     = r_cur_y;

  always_comb begin
    w_state_nxt     = r_state;
    w_mode_nxt      = r_mode;
    w_cur_x_nxt     = r_cur_x;
    w_cur_y_nxt     = r_cur_y;
    w_clr_x_nxt     = r_clr_x;
    w_clr_y_nxt     = r_clr_y;
    w_wr_en_nxt     = 1'b0;
    w_wr_x_nxt      = r_wr_x;
    w_wr_y_nxt      = r_wr_y;
    w_wr_ascii_nxt  = r_wr_ascii;
    w_wr_colour_nxt = r_wr_colour;

    case (r_state)
      S_IDLE: begin
        if (w_mismatch) begin
          w_mode_nxt  = bus.sL;
          w_clr_x_nxt = 7'd0;
          w_clr_y_nxt = w_top_sl;
          w_state_nxt = S_CLR_SCR;
        end else if (w_accept) begin
          if (w_printable) begin
            w_wr_en_nxt     = 1'b1;
            w_wr_x_nxt      = r_cur_x;
            w_wr_y_nxt      = r_cur_y;
            w_wr_ascii_nxt  = bus.char_ascii;
            w_wr_colour_nxt = bus.char_colour;
            if (r_cur_x == w_last_x) begin
              w_cur_x_nxt = 7'd0;
              w_cur_y_nxt = w_next_row;
              w_state_nxt = S_PEND;
            end else begin
              w_cur_x_nxt = r_cur_x + 7'd1;
            end
          end else begin
            case (bus.char_ascii)
              7'h0A: begin
                // Column 0 of the new row is written now so the clear ends on time
                w_cur_x_nxt     = 7'd0;
                w_cur_y_nxt     = w_next_row;
                w_wr_en_nxt     = 1'b1;
                w_wr_x_nxt      = 7'd0;
                w_wr_y_nxt      = w_next_row;
                w_wr_ascii_nxt  = c_SPACE;
                w_wr_colour_nxt = c_BLACK;
                w_clr_x_nxt     = 7'd1;
                w_state_nxt     = S_CLR_ROW;
              end
              7'h0D: w_cur_x_nxt = 7'd0;
              7'h08: begin
                if (r_cur_x != 7'd0) begin
                  w_cur_x_nxt     = r_cur_x - 7'd1;
                  w_wr_en_nxt     = 1'b1;
                  w_wr_x_nxt      = r_cur_x - 7'd1;
                  w_wr_y_nxt      = r_cur_y;
                  w_wr_ascii_nxt  = c_SPACE;
                  w_wr_colour_nxt = c_BLACK;
                end
              end
              7'h0C: begin
                w_mode_nxt  = bus.sL;
                w_clr_x_nxt = 7'd0;
                w_clr_y_nxt = w_top_sl;
                w_state_nxt = S_CLR_SCR;
              end
              default: ;
            endcase
          end
        end
      end

      S_PEND: begin
        w_wr_en_nxt     = 1'b1;
        w_wr_x_nxt      = 7'd0;
        w_wr_y_nxt      = r_cur_y;
        w_wr_ascii_nxt  = c_SPACE;
        w_wr_colour_nxt = c_BLACK;
        w_clr_x_nxt     = 7'd1;
        w_state_nxt     = S_CLR_ROW;
      end

      S_CLR_ROW: begin
        if (r_clr_x == w_cols) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_wr_en_nxt     = 1'b1;
          w_wr_x_nxt      = r_clr_x;
          w_wr_y_nxt      = r_cur_y;
          w_wr_ascii_nxt  = c_SPACE;
          w_wr_colour_nxt = c_BLACK;
          w_clr_x_nxt     = r_clr_x + 7'd1;
        end
      end

      S_CLR_SCR: begin
        w_wr_en_nxt     = 1'b1;
        w_wr_x_nxt      = r_clr_x;
        w_wr_y_nxt      = r_clr_y;
        w_wr_ascii_nxt  = c_SPACE;
        w_wr_colour_nxt = c_BLACK;
        if (r_clr_x == w_last_x) begin
          w_clr_x_nxt = 7'd0;
          if (r_clr_y == 6'd0) begin
            w_cur_x_nxt = 7'd0;
            w_cur_y_nxt = w_top;
            w_state_nxt = S_IDLE;
          end else begin
            w_clr_y_nxt = r_clr_y - 6'd1;
          end
        end else begin
          w_clr_x_nxt = r_clr_x + 7'd1;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_CLR_SCR;
      r_mode      <= bus.sL;
      r_cur_x     <= 7'd0;
      r_cur_y     <= w_top_sl;
      r_clr_x     <= 7'd0;
      r_clr_y     <= w_top_sl;
      r_wr_en     <= 1'b0;
      r_wr_x      <= 7'd0;
      r_wr_y      <= 6'd0;
      r_wr_ascii  <= 7'd0;
      r_wr_colour <= 6'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_mode      <= w_mode_nxt;
      r_cur_x     <= w_cur_x_nxt;
      r_cur_y     <= w_cur_y_nxt;
      r_clr_x     <= w_clr_x_nxt;
      r_clr_y     <= w_clr_y_nxt;
      r_wr_en     <= w_wr_en_nxt;
      r_wr_x      <= w_wr_x_nxt;
      r_wr_y      <= w_wr_y_nxt;
      r_wr_ascii  <= w_wr_ascii_nxt;
      r_wr_colour <= w_wr_colour_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_text_console_writer.sv
// +-----------------------------------------------------------------------+
// | tb_text_console_writer                                                |
// | Directed checks of the text console writer in both geometries.        |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_text_console_writer;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  text_console_writer_if bus ();

  text_console_writer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [6:0] a, input logic [5:0] c);
    int n;
    n = 0;
    while (!bus.char_ready && n < 2000) begin
      tick();
      n++;
    end
    if (!bus.char_ready) begin
      tests++;
      fails++;
      $error("FAIL send_ready: observed 0 expected 1");
    end
    bus.char_valid  = 1'b1;
    bus.char_ascii  = a;
    bus.char_colour = c;
    tick();
    bus.char_valid  = 1'b0;
  endtask

  // Samples the current cycle first, then steps until ready is seen
  task automatic drain(input int budget, input int row,
                       output int nw, output int nrow, output int nlow, output int bad,
                       output int fx, output int fy, output int lx, output int ly);
    int  i;
    bit  done;
    nw = 0; nrow = 0; nlow = 0; bad = 0;
    fx = -1; fy = -1; lx = -1; ly = -1;
    done = 1'b0;
    i = 0;
    while (!done && i < budget) begin
      if (bus.wr_en) begin
        if (nw == 0) begin
          fx = int'(bus.wr_x);
          fy = int'(bus.wr_y);
        end
        lx = int'(bus.wr_x);
        ly = int'(bus.wr_y);
        nw++;
        if (int'(bus.wr_y) == row) nrow++;
        if (bus.wr_ascii !== 7'h20 || bus.wr_colour !== 6'd0) bad++;
      end
      if (bus.char_ready) begin
        done = 1'b1;
      end else begin
        nlow++;
        tick();
        i++;
      end
    end
    if (!done) begin
      tests++;
      fails++;
      $error("FAIL drain_timeout: observed ready 0 expected 1 within %0d cycles", budget);
    end
  endtask

  int nw, nrow, nlow, bad, fx, fy, lx, ly;

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.sL          = 1'b0;
    bus.char_valid  = 1'b0;
    bus.char_ascii  = 7'd0;
    bus.char_colour = 6'd0;
    repeat (3) tick();

    // Reset state, small geometry
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_wr_x", bus.wr_x, 0);
    chk("rst_wr_y", bus.wr_y, 0);
    chk("rst_ready", bus.char_ready, 0);
    chk("rst_cur_x", bus.cur_x, 0);
    chk("rst_cur_y", bus.cur_y, 59);

    reset = 1'b0;
    tick();
    drain(6000, 59, nw, nrow, nlow, bad, fx, fy, lx, ly);
    chk("scr_small_count", nw, 4800);
    chk("scr_small_first_x", fx, 0);
    chk("scr_small_first_y", fy, 59);
    chk("scr_small_last_x", lx, 79);
    chk("scr_small_last_y", ly, 0);
    chk("scr_small_blank", bad, 0);
    chk("scr_small_ready", bus.char_ready, 1);
    chk("scr_small_cur_x", bus.cur_x, 0);
    chk("scr_small_cur_y", bus.cur_y, 59);

    // "AB" back to back
    send(7'h41, 6'h3F);
    chk("A_wr_en", bus.wr_en, 1);
    chk("A_wr_x", bus.wr_x, 0);
    chk("A_wr_y", bus.wr_y, 59);
    chk("A_ascii", bus.wr_ascii, 7'h41);
    chk("A_colour", bus.wr_colour, 6'h3F);
    chk("A_ready", bus.char_ready, 1);
    send(7'h42, 6'h3F);
    chk("B_wr_en", bus.wr_en, 1);
    chk("B_wr_x", bus.wr_x, 1);
    chk("B_ascii", bus.wr_ascii, 7'h42);
    chk("B_ready", bus.char_ready, 1);
    chk("B_cur_x", bus.cur_x, 2);
    chk("B_cur_y", bus.cur_y, 59);

    // Walk down to the bottom row and fill it to column 79
    for (int k = 0; k < 59; k++) begin
      send(7'h0A, 6'd0);
      drain(200, -1, nw, nrow, nlow, bad, fx, fy, lx, ly);
    end
    chk("walk_cur_y", bus.cur_y, 0);
    for (int k = 0; k < 79; k++) send(7'h78, 6'h05);
    chk("fill_cur_x", bus.cur_x, 79);

    // Printable at the last column wraps to the top row
    send(7'h5A, 6'h15);
    chk("Z_wr_en", bus.wr_en, 1);
    chk("Z_wr_x", bus.wr_x, 79);
    chk("Z_wr_y", bus.wr_y, 0);
    chk("Z_ascii", bus.wr_ascii, 7'h5A);
    chk("Z_colour", bus.wr_colour, 6'h15);
    chk("Z_ready", bus.char_ready, 0);
    tick();
    drain(300, 59, nw, nrow, nlow, bad, fx, fy, lx, ly);
    chk("Z_clr_count", nw, 80);
    chk("Z_clr_row", nrow, 80);
    chk("Z_clr_blank", bad, 0);
    chk("Z_clr_first_x", fx, 0);
    chk("Z_clr_last_x", lx, 79);
    chk("Z_low_cycles", nlow + 1, 81);
    chk("Z_cur_x", bus.cur_x, 0);
    chk("Z_cur_y", bus.cur_y, 59);

    // Geometry flip during a line-feed row clear
    send(7'h0A, 6'd0);
    bus.sL = 1'b1;
    drain(3000, 58, nw, nrow, nlow, bad, fx, fy, lx, ly);
    chk("flip_count", nw, 1280);
    chk("flip_row58", nrow, 80);
    chk("flip_first_y", fy, 58);
    chk("flip_last_x", lx, 39);
    chk("flip_last_y", ly, 0);
    chk("flip_blank", bad, 0);
    chk("flip_cur_x", bus.cur_x, 0);
    chk("flip_cur_y", bus.cur_y, 29);

    // LF at (5,29) in large geometry
    for (int k = 0; k < 5; k++) send(7'h61, 6'h0A);
    chk("large_cur_x", bus.cur_x, 5);
    send(7'h0A, 6'd0);
    drain(200, 28, nw, nrow, nlow, bad, fx, fy, lx, ly);
    chk("lf_count", nw, 40);
    chk("lf_row", nrow, 40);
    chk("lf_low_cycles", nlow, 40);
    chk("lf_last_x", lx, 39);
    chk("lf_cur_x", bus.cur_x, 0);
    chk("lf_cur_y", bus.cur_y, 28);

    // Backspace at (3,10) and at (0,10)
    for (int k = 0; k < 18; k++) begin
      send(7'h0A, 6'd0);
      drain(200, -1, nw, nrow, nlow, bad, fx, fy, lx, ly);
    end
    for (int k = 0; k < 3; k++) send(7'h63, 6'h11);
    chk("bs_pre_cur_x", bus.cur_x, 3);
    chk("bs_pre_cur_y", bus.cur_y, 10);
    send(7'h08, 6'h2A);
    chk("bs_wr_en", bus.wr_en, 1);
    chk("bs_wr_x", bus.wr_x, 2);
    chk("bs_wr_y", bus.wr_y, 10);
    chk("bs_ascii", bus.wr_ascii, 7'h20);
    chk("bs_colour", bus.wr_colour, 0);
    chk("bs_cur_x", bus.cur_x, 2);
    send(7'h0D, 6'd0);
    chk("cr_wr_en", bus.wr_en, 0);
    chk("cr_cur_x", bus.cur_x, 0);
    send(7'h08, 6'd0);
    chk("bs0_wr_en", bus.wr_en, 0);
    chk("bs0_cur_x", bus.cur_x, 0);
    chk("bs0_cur_y", bus.cur_y, 10);
    chk("bs0_ready", bus.char_ready, 1);
    send(7'h7F, 6'h3F);
    chk("del_wr_en", bus.wr_en, 0);
    chk("del_cur_x", bus.cur_x, 0);

    // Form feed clears the large screen
    send(7'h0C, 6'd0);
    drain(2000, -1, nw, nrow, nlow, bad, fx, fy, lx, ly);
    chk("ff_count", nw, 1200);
    chk("ff_first_y", fy, 29);
    chk("ff_cur_x", bus.cur_x, 0);
    chk("ff_cur_y", bus.cur_y, 29);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/text_console_writer.md
# text_console_writer

Writer side of the character/colour buffer that the VGA text renderer scans. It accepts a stream of ASCII bytes with a colour and converts them into single-cell buffer writes at a hardware cursor. It handles printable output, line control and screen/line clearing in both text geometries: small is 80x60 cells of 8x8 pixels, large is 40x30 cells of 16x16 pixels. Buffer row numbering matches the renderer: the top screen line is the highest row index, so moving down the screen decrements the row.

## Interface
- No parameters; geometry is selected at run time by `sL`.
- `clk` in 1: system clock, also the buffer write clock.
- `reset` in 1: synchronous, active-high.
- `sL` in 1: geometry select. 1 = large (40 cols, 30 rows). 0 = small (80 cols, 60 rows).
- `char_valid` in 1: byte offered.
- `char_ascii` in 7: byte value.
- `char_colour` in 6: colour for printable bytes.
- `char_ready` out 1: byte accepted when `char_valid && char_ready`.
- `wr_en` out 1: one buffer write this cycle.
- `wr_x` out 7: write column.
- `wr_y` out 6: write row.
- `wr_ascii` out 7: write character.
- `wr_colour` out 6: write colour.
- `cur_x` out 7: cursor column.
- `cur_y` out 6: cursor row.

## Operation
- Geometry register `mode_q` is latched on every entry to CLR_SCR and used everywhere else.
  - COLS = 40 when `mode_q` = 1, else 80.
  - TOP = 29 when `mode_q` = 1, else 59.
  - "Next row" is `cur_y - 1`; from row 0 it wraps to TOP.
- States: IDLE, PEND, CLR_ROW, CLR_SCR. `char_ready` = (state == IDLE), combinational.
- Accepted byte in IDLE:
  - **Printable, 0x20-0x7E, `cur_x` < COLS-1:** write (`cur_x`, `cur_y`, byte, `char_colour`). `cur_x` +1. Stay IDLE.
  - **Printable, `cur_x` = COLS-1:** write the cell. Cursor goes to (0, next row). Go to PEND.
  - **0x0A LF:** cursor goes to (0, next row). Go to CLR_ROW. No character write.
  - **0x0D CR:** `cur_x` = 0. No write.
  - **0x08 BS, `cur_x` > 0:** `cur_x` -1. Write space (0x20, colour 0) at the new `cur_x`.
  - **0x08 BS, `cur_x` = 0:** no-op; the byte is still consumed.
  - **0x0C FF:** go to CLR_SCR.
  - **Any other byte** (0x00-0x1F not listed above, 0x7F): consumed and ignored.
- PEND: lasts one cycle, ready low, then CLR_ROW.
- CLR_ROW: writes (x, `cur_y`, 0x20, 6'b000000) for x = 0..COLS-1, one per cycle, then IDLE.
- CLR_SCR:
  - Writes space/black to every cell in row-major order: y = TOP down to 0, x = 0..COLS-1 within each row.
  - On completion, cursor = (0, TOP) and state goes to IDLE.
- Geometry change:
  - A mismatch between `sL` and `mode_q` is checked only in IDLE. It takes priority over an offered byte (ready is forced low that cycle) and goes to CLR_SCR.
  - `sL` changes during PEND, CLR_ROW or CLR_SCR do not disturb the operation in progress; they are picked up on the next IDLE cycle.
- Column counter is 7 bits and row counter is 6 bits; all comparisons use the latched COLS and TOP.

## Timing
- All `wr_*` outputs and the cursor are registered.
- A byte accepted in cycle N produces its write in cycle N+1. The cursor shows its new value in N+1.
- Back-to-back printable bytes (no wrap): one write per cycle, ready held high.
- LF accepted in N: clear writes in N+1..N+COLS. Ready low in N+1..N+COLS, high in N+COLS+1.
- Printable at the last column, accepted in N:
  - Character write in N+1 (PEND).
  - Clear writes in N+2..N+COLS+1.
  - Ready high in N+COLS+2.
- CLR_SCR entered in N: COLS*(TOP+1) writes (4800 small, 1200 large), then IDLE.
- `wr_en` = 0 whenever no write occurs; the other `wr_*` outputs hold their last values.
- Reset:
  - All outputs go to 0, with the cursor at (0, TOP of `sL`).
  - `mode_q` = `sL`, state = CLR_SCR, so ready is low.
  - The first clear write appears in the cycle after reset deasserts.
  - Reset mid-operation aborts the operation and restarts the full clear.

## Test plan
- **Reset, `sL`=0:** exactly 4800 writes, first (0,59), last (79,0), all 0x20/black. Then ready=1 with cursor (0,59).
- **"AB" back-to-back, colour 6'h3F, at (0,59):**
  - Writes (0,59,'A') then (1,59,'B') on consecutive cycles.
  - Ready never drops; cursor ends at (2,59).
- **'Z' at (79,0), `sL`=0:**
  - Write (79,0,'Z'), then 80 clear writes on row 59.
  - Ready low for 81 cycles; cursor ends at (0,59).
- **LF at (5,29), `sL`=1:** 40 clear writes on row 28; cursor (0,28).
- **BS at (3,10) then BS at (0,10):**
  - First writes space at (2,10).
  - Second is consumed with no write and no cursor change.
- **Flip `sL` 0->1 mid-LF clear:** the 80-write row clear completes, then a 1200-write clear, then cursor (0,29).
